// File: rtl/lif_neuron_if.sv
// lif_neuron_if: activation bus into the neuron and spike/membrane outputs back out
interface lif_neuron_if #(
   parameter int N_SYN = 4,
   parameter int V_W   = 12
);
   logic                 en;
   logic [N_SYN*8-1:0]   activation_in;
   logic                 post_spike;
   logic [V_W-1:0]       membrane;
   logic                 refractory;

   modport master (
      output en, activation_in,
      input  post_spike, membrane, refractory
   );

   modport slave (
      input  en, activation_in,
      output post_spike, membrane, refractory
   );
endinterface

// File: rtl/lif_neuron.sv
// lif_neuron: leaky integrate-and-fire neuron with saturating membrane and refractory period
module lif_neuron #(
   parameter int N_SYN      = 4,
   parameter int V_W        = 12,
   parameter int THRESHOLD  = 200,
   parameter int LEAK_SHIFT = 3,
   parameter int REFRACT    = 4
) (
   input logic         clk,
   input logic         reset,
   lif_neuron_if.slave bus
);
   localparam int SW = 8 + $clog2(N_SYN);
   localparam int CW = REFRACT > 1 ? $clog2(REFRACT) : 1;
   localparam logic [V_W-1:0] TH = V_W'(THRESHOLD);
   localparam logic [CW-1:0] CNT_INIT = CW'(REFRACT > 0 ? REFRACT - 1 : 0);

   typedef enum logic [1:0] {
      ST_INTEGRATE = 2'd0,
      ST_FIRE      = 2'd1,
      ST_REFRACT   = 2'd2
   } state_t;

   state_t          state, state_nx;
   logic [V_W-1:0]  v, v_nx, shifted, leak, v_sat;
   logic [V_W:0]    v_sum;
   logic [SW-1:0]   sum;
   logic [CW-1:0]   cnt, cnt_nx;
   logic            post_spike, refractory;

   // sum of all activation bytes; width chosen so it cannot overflow
   always_comb begin
      sum = '0;
      for (int k = 0; k < N_SYN; k++) sum += SW'(bus.activation_in[8*k +: 8]);
   end

   // leak of at least 1 for any nonzero v so the potential always decays to 0
   assign shifted = v >> LEAK_SHIFT;
   assign leak    = (v != '0 && shifted == '0) ? V_W'(1) : shifted;
   assign v_sum   = {1'b0, v} - {1'b0, leak} + (V_W+1)'(sum);
   assign v_sat   = v_sum[V_W] ? '1 : v_sum[V_W-1:0];

   // next state, membrane and refractory counter
   always_comb begin
      state_nx = state;
      v_nx     = v;
      cnt_nx   = cnt;
      case (state)
         ST_INTEGRATE: begin
            if (bus.en) begin
               if (v_sat >= TH) begin
                  state_nx = ST_FIRE;
                  v_nx     = '0;
               end else begin
                  v_nx = v_sat;
               end
            end
         end
         ST_FIRE: begin
            v_nx   = '0;
            cnt_nx = CNT_INIT;
            if (REFRACT > 0) state_nx = ST_REFRACT;
            else             state_nx = ST_INTEGRATE;
         end
         ST_REFRACT: begin
            v_nx = '0;
            if (cnt == '0) state_nx = ST_INTEGRATE;
            else           cnt_nx   = cnt - CW'(1);
         end
         default: begin
            state_nx = ST_INTEGRATE;
            v_nx     = '0;
         end
      endcase
   end

   // state register; spike and refractory flags registered from the next state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_INTEGRATE;
         v          <= '0;
         cnt        <= '0;
         post_spike <= 1'b0;
         refractory <= 1'b0;
      end else begin
         state      <= state_nx;
         v          <= v_nx;
         cnt        <= cnt_nx;
         post_spike <= state_nx == ST_FIRE;
         refractory <= state_nx == ST_REFRACT;
      end
   end

   assign bus.post_spike = post_spike;
   assign bus.membrane   = v;
   assign bus.refractory = refractory;
endmodule

// File: tb/tb_lif_neuron.sv
// tb_lif_neuron: directed scenarios for the LIF neuron across default, saturating and zero-refractory builds
module tb_lif_neuron;
   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   lif_neuron_if ia ();
   lif_neuron_if ib ();
   lif_neuron_if ic ();

   lif_neuron u_a (.clk(clk), .reset(reset), .bus(ia));
   lif_neuron #(.THRESHOLD(4095)) u_b (.clk(clk), .reset(reset), .bus(ib));
   lif_neuron #(.REFRACT(0)) u_c (.clk(clk), .reset(reset), .bus(ic));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ia.en = 1'b0; ia.activation_in = '0;
      ib.en = 1'b0; ib.activation_in = '0;
      ic.en = 1'b0; ic.activation_in = '0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b0;
      #2;
      checks++; if (ia.membrane !== 12'd0) begin errors++; $display("FAIL reset_membrane got %0d want 0", ia.membrane); end
      checks++; if (ia.post_spike !== 1'b0) begin errors++; $display("FAIL reset_spike got %b want 0", ia.post_spike); end
      checks++; if (ia.refractory !== 1'b0) begin errors++; $display("FAIL reset_refr got %b want 0", ia.refractory); end
      tick();
      reset = 1'b1;
      ia.en = 1'b1;
      ia.activation_in = 32'd150;
      tick();
      checks++; if (ia.membrane !== 12'd150) begin errors++; $display("FAIL reset_pre got %0d want 150", ia.membrane); end
      ia.activation_in = '0;
      #2;
      reset = 1'b0;
      #1;
      checks++; if (ia.membrane !== 12'd0) begin errors++; $display("FAIL reset_async_membrane got %0d want 0", ia.membrane); end
      reset = 1'b1;
      ia.activation_in = '1;
      tick();
      checks++; if (ia.post_spike !== 1'b1) begin errors++; $display("FAIL reset_fire got %b want 1", ia.post_spike); end
      tick();
      checks++; if (ia.refractory !== 1'b1) begin errors++; $display("FAIL reset_in_refr got %b want 1", ia.refractory); end
      #2;
      reset = 1'b0;
      #1;
      checks++; if (ia.refractory !== 1'b0) begin errors++; $display("FAIL reset_mid_refr got %b want 0", ia.refractory); end
      checks++; if (ia.post_spike !== 1'b0) begin errors++; $display("FAIL reset_mid_spike got %b want 0", ia.post_spike); end
      ia.activation_in = 32'd100;
      #2;
      reset = 1'b1;
      tick();
      checks++; if (ia.membrane !== 12'd100) begin errors++; $display("FAIL reset_resume got %0d want 100", ia.membrane); end
      checks++; if (ia.refractory !== 1'b0) begin errors++; $display("FAIL reset_resume_refr got %b want 0", ia.refractory); end
   endtask

   task automatic test_fire();
      int   exp_v [9];
      logic exp_s [9];
      logic exp_r [9];
      exp_v = '{100, 188, 0, 0, 0, 0, 0, 0, 100};
      exp_s = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
      exp_r = '{0, 0, 0, 1, 1, 1, 1, 0, 0};
      do_reset();
      ia.en = 1'b1;
      ia.activation_in = 32'd100;
      for (int i = 0; i < 9; i++) begin
         tick();
         checks++; if (ia.membrane !== 12'(exp_v[i])) begin errors++; $display("FAIL fire_membrane[%0d] got %0d want %0d", i, ia.membrane, exp_v[i]); end
         checks++; if (ia.post_spike !== exp_s[i]) begin errors++; $display("FAIL fire_spike[%0d] got %b want %b", i, ia.post_spike, exp_s[i]); end
         checks++; if (ia.refractory !== exp_r[i]) begin errors++; $display("FAIL fire_refr[%0d] got %b want %b", i, ia.refractory, exp_r[i]); end
      end
   endtask

   task automatic test_leak();
      int exp_v [7];
      int spikes;
      exp_v = '{150, 132, 116, 102, 90, 79, 70};
      spikes = 0;
      do_reset();
      ia.en = 1'b1;
      ia.activation_in = 32'd150;
      for (int i = 0; i < 7; i++) begin
         tick();
         ia.activation_in = '0;
         if (ia.post_spike) spikes++;
         checks++; if (ia.membrane !== 12'(exp_v[i])) begin errors++; $display("FAIL leak_membrane[%0d] got %0d want %0d", i, ia.membrane, exp_v[i]); end
      end
      for (int i = 0; i < 60; i++) begin
         tick();
         if (ia.post_spike) spikes++;
      end
      checks++; if (ia.membrane !== 12'd0) begin errors++; $display("FAIL leak_to_zero got %0d want 0", ia.membrane); end
      checks++; if (spikes !== 0) begin errors++; $display("FAIL leak_no_spike got %0d spikes want 0", spikes); end
   endtask

   task automatic test_saturation();
      int exp_v [5];
      exp_v = '{1020, 1913, 2694, 3378, 3976};
      do_reset();
      ib.en = 1'b1;
      ib.activation_in = '1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (ib.membrane !== 12'(exp_v[i])) begin errors++; $display("FAIL sat_membrane[%0d] got %0d want %0d", i, ib.membrane, exp_v[i]); end
         checks++; if (ib.post_spike !== 1'b0) begin errors++; $display("FAIL sat_early_spike[%0d] got %b want 0", i, ib.post_spike); end
      end
      tick();
      checks++; if (ib.post_spike !== 1'b1) begin errors++; $display("FAIL sat_fire got %b want 1", ib.post_spike); end
      checks++; if (ib.membrane !== 12'd0) begin errors++; $display("FAIL sat_fire_membrane got %0d want 0", ib.membrane); end
   endtask

   task automatic test_refractory_gating();
      logic exp_s [7];
      logic exp_r [7];
      logic exp_c [6];
      exp_s = '{1, 0, 0, 0, 0, 0, 1};
      exp_r = '{0, 1, 1, 1, 1, 0, 0};
      exp_c = '{1, 0, 1, 0, 1, 0};
      do_reset();
      ia.en = 1'b1;
      ia.activation_in = '1;
      for (int i = 0; i < 7; i++) begin
         tick();
         checks++; if (ia.post_spike !== exp_s[i]) begin errors++; $display("FAIL gate_spike[%0d] got %b want %b", i, ia.post_spike, exp_s[i]); end
         checks++; if (ia.refractory !== exp_r[i]) begin errors++; $display("FAIL gate_refr[%0d] got %b want %b", i, ia.refractory, exp_r[i]); end
         checks++; if (ia.membrane !== 12'd0) begin errors++; $display("FAIL gate_membrane[%0d] got %0d want 0", i, ia.membrane); end
      end
      ia.en = 1'b0;
      ic.en = 1'b1;
      ic.activation_in = '1;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++; if (ic.post_spike !== exp_c[i]) begin errors++; $display("FAIL r0_spike[%0d] got %b want %b", i, ic.post_spike, exp_c[i]); end
         checks++; if (ic.refractory !== 1'b0) begin errors++; $display("FAIL r0_refr[%0d] got %b want 0", i, ic.refractory); end
      end
   endtask

   task automatic test_refractory_ignores_en();
      do_reset();
      ia.en = 1'b1;
      ia.activation_in = '1;
      tick();
      ia.en = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      checks++; if (ia.refractory !== 1'b0) begin errors++; $display("FAIL en_refr_done got %b want 0", ia.refractory); end
      ia.en = 1'b1;
      ia.activation_in = 32'd50;
      tick();
      checks++; if (ia.membrane !== 12'd50) begin errors++; $display("FAIL en_refr_resume got %0d want 50", ia.membrane); end
   endtask

   task automatic test_enable();
      do_reset();
      ia.en = 1'b1;
      ia.activation_in = 32'd100;
      tick();
      tick();
      checks++; if (ia.membrane !== 12'd188) begin errors++; $display("FAIL en_pre got %0d want 188", ia.membrane); end
      ia.en = 1'b0;
      ia.activation_in = '1;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++; if (ia.membrane !== 12'd188) begin errors++; $display("FAIL en_hold[%0d] got %0d want 188", i, ia.membrane); end
         checks++; if (ia.post_spike !== 1'b0) begin errors++; $display("FAIL en_hold_spike[%0d] got %b want 0", i, ia.post_spike); end
      end
      ia.en = 1'b1;
      ia.activation_in = 32'd100;
      tick();
      checks++; if (ia.post_spike !== 1'b1) begin errors++; $display("FAIL en_fire got %b want 1", ia.post_spike); end
      checks++; if (ia.membrane !== 12'd0) begin errors++; $display("FAIL en_fire_membrane got %0d want 0", ia.membrane); end
   endtask

   initial begin
      reset = 1'b1;
      idle();
      test_reset();
      test_fire();
      test_leak();
      test_saturation();
      test_refractory_gating();
      test_refractory_ignores_en();
      test_enable();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/lif_neuron.md
Name: lif_neuron

Overview:
- Post-synaptic leaky integrate-and-fire neuron: the consumer of synapse activation buses and the producer of the post_spike that synapses use for weight updates.
- Each cycle it does four things:
  - sums N_SYN 8-bit activations;
  - integrates the sum into a leaking membrane potential;
  - fires a one-cycle post_spike when the threshold is reached;
  - enters a refractory period.
- Sits between a bank of synapses and the next layer / synapse post_spike inputs.

Parameters:
- N_SYN, 4: number of 8-bit activation inputs.
- V_W, 12: membrane potential width in bits (must be >= 8 + clog2(N_SYN)).
- THRESHOLD, 200: firing threshold, 1 .. 2^V_W-1.
- LEAK_SHIFT, 3: leak = v >> LEAK_SHIFT per integrating cycle.
- REFRACT, 4: refractory length in cycles, 0 allowed.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  integration enable.
- activation_in  input  N_SYN*8  synapse k occupies bits 8k+7..8k, unsigned.
- post_spike  output  1  registered one-cycle fire pulse.
- membrane  output  V_W  registered membrane potential v.
- refractory  output  1  high while in REFRACT state.

Behaviour:
- Reset (reset=0, asynchronous, any time including mid-refractory):
  - state=INTEGRATE, v=0, post_spike=0, refractory=0, refractory counter=0.
  - Outputs change without waiting for clk.
- States: INTEGRATE, FIRE, REFRACT; 2-bit encoded.
- sum = unsigned sum of all N_SYN bytes, width 8+clog2(N_SYN), no overflow possible.
- leak (function of v): 0 if v=0; 1 if 0<v<2^LEAK_SHIFT; else v>>LEAK_SHIFT (floor). This guarantees decay to 0.
- INTEGRATE with en=1:
  - v_next = min(v - leak + sum, 2^V_W-1); intermediate width V_W+1, saturating.
  - If v_next >= THRESHOLD: at this edge state<=FIRE, post_spike<=1, v<=0.
  - Else v<=v_next, post_spike<=0.
- INTEGRATE with en=0: v held (no leak, no input), post_spike=0.
- FIRE (exactly one cycle, post_spike=1 during it, v=0):
  - REFRACT>0: next edge state<=REFRACT, counter<=REFRACT-1, refractory<=1, post_spike<=0.
  - REFRACT=0: next edge state<=INTEGRATE, post_spike<=0.
  - activation_in ignored.
- REFRACT:
  - v held at 0; activation_in ignored; refractory=1.
  - counter decrements each edge; when counter=0, next edge goes to INTEGRATE with refractory<=0.
  - Total refractory-high time = REFRACT cycles.
- en affects INTEGRATE only; FIRE/REFRACT timing advances regardless of en.
- Latency: an input sampled at edge k affects membrane/post_spike visible after edge k. Minimum spike-to-spike spacing is REFRACT+2 cycles.
- Simultaneous events:
  - Threshold crossing and saturation on the same edge → fire (saturated value compared).
  - Inputs arriving on the firing edge are consumed into the fired value and discarded; no carry-over.
- post_spike is never high for two consecutive cycles.

Test Plan:
- Reset: run to v=150, pull reset low between edges → membrane=0, post_spike=0, refractory=0 immediately. Release → integration resumes from 0.
- Fire (defaults): syn0=100, others 0, en=1:
  - v after edges 1,2 = 100, 188.
  - Edge 3 computes 265 → post_spike=1 for one cycle, membrane=0.
  - refractory=1 for next 4 cycles with v=0, then v=100 one edge after refractory falls.
- Leak: apply syn0=150 for one edge then all zeros → membrane 150, 132, 116, 102, ...
  - Once v<8 it decrements by 1 per cycle to 0 and stays 0.
  - No post_spike throughout.
- Saturation: THRESHOLD=4095, all four inputs 255 → v = 1020, 1913, 2694, 3378, 3976, then 4499 clipped to 4095 → fires on the 6th edge; membrane never exceeds 4095.
- Refractory gating: all inputs 255 held after a spike → v stays 0 and no post_spike for FIRE+4 cycles; next spike follows the earliest legal integration.
  - With REFRACT=0, post_spike pulses with one-cycle gaps, never back-to-back.
- Enable: reach v=188, drop en for 10 cycles → membrane stays 188 and post_spike stays 0. Raise en with syn0=100 → fires on the next edge (v_next=265).
